// File: rtl/array_max_pkg.sv
// Shared types for the array maximum scanner: FSM state encoding and RAM read latency.
package array_max_pkg;

    localparam int unsigned RD_LAT = 1;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/array_max_scan.sv
// Scans an array through a synchronous RAM read port and reports the maximum value and the
// index of its first occurrence once the index stream has ended and the reads have drained.
module array_max_scan
    import array_max_pkg::*;
#(
    parameter int unsigned SIZE_ADDR = 8,
    parameter int unsigned SIZE_DATA = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_en,
    input  logic [SIZE_ADDR-1:0] i_value_i,
    input  logic                 i_done,
    output logic                 o_rd_en,
    output logic [SIZE_ADDR-1:0] o_rd_addr,
    input  logic [SIZE_DATA-1:0] i_rd_data,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [SIZE_DATA-1:0] o_max,
    output logic [SIZE_ADDR-1:0] o_max_idx
);

    state_e               r_state;
    logic [RD_LAT:0]      r_vld;
    logic [SIZE_ADDR-1:0] r_idx_pipe [RD_LAT];
    logic [SIZE_ADDR-1:0] r_rd_addr;
    logic [SIZE_DATA-1:0] r_max;
    logic [SIZE_ADDR-1:0] r_max_idx;
    logic                 r_first;
    logic                 r_busy;
    logic                 r_valid;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_data_vld;
    logic                 w_take;
    logic                 w_drained;

    // The index arriving with i_start is the first element of the new scan.
    assign w_accept   = i_en && (i_start || (r_state == StScan));
    assign w_last     = w_accept && i_done;
    assign w_data_vld = r_vld[RD_LAT];
    assign w_take     = w_data_vld && (r_first || (i_rd_data > r_max));
    assign w_drained  = w_data_vld && (r_vld[RD_LAT-1:0] == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_vld     <= '0;
            r_rd_addr <= '0;
            r_max     <= '0;
            r_max_idx <= '0;
            r_first   <= 1'b1;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_idx_pipe[k] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_rd_addr <= i_value_i;
            end
            r_idx_pipe[0] <= r_rd_addr;
            for (int k = 1; k < RD_LAT; k++) begin
                r_idx_pipe[k] <= r_idx_pipe[k-1];
            end

            if (i_start) begin
                // Restart discards reads still in flight from the previous scan.
                r_vld     <= {{RD_LAT{1'b0}}, w_accept};
                r_first   <= 1'b1;
                r_max     <= '0;
                r_max_idx <= '0;
                r_busy    <= 1'b1;
                r_valid   <= 1'b0;
                r_state   <= w_last ? StDrain : StScan;
            end else begin
                r_vld   <= {r_vld[RD_LAT-1:0], w_accept};
                r_valid <= 1'b0;

                if (w_take) begin
                    r_max     <= i_rd_data;
                    r_max_idx <= r_idx_pipe[RD_LAT-1];
                    r_first   <= 1'b0;
                end

                case (r_state)
                    StScan: begin
                        if (w_last) begin
                            r_state <= StDrain;
                        end
                    end
                    StDrain: begin
                        if (w_drained) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign o_rd_en   = r_vld[0];
    assign o_rd_addr = r_rd_addr;
    assign o_busy    = r_busy;
    assign o_valid   = r_valid;
    assign o_max     = r_max;
    assign o_max_idx = r_max_idx;

endmodule

// File: tb/tb_array_max_scan.sv
// Directed bench for array_max_scan with a behavioural 1-cycle synchronous RAM.
module tb_array_max_scan;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic        i_en;
    logic [7:0]  i_value_i;
    logic        i_done;
    logic        o_rd_en;
    logic [7:0]  o_rd_addr;
    logic [15:0] rd_data;
    logic        o_busy;
    logic        o_valid;
    logic [15:0] o_max;
    logic [7:0]  o_max_idx;

    logic [15:0] mem [256];

    int checks;
    int errors;
    int cyc;
    int start_cyc;
    int valid_cyc;
    int valid_cnt;
    int rd_cnt;
    int vbase;
    int rbase;

    array_max_scan #(
        .SIZE_ADDR(8),
        .SIZE_DATA(16)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (i_start),
        .i_en      (i_en),
        .i_value_i (i_value_i),
        .i_done    (i_done),
        .o_rd_en   (o_rd_en),
        .o_rd_addr (o_rd_addr),
        .i_rd_data (rd_data),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_max     (o_max),
        .o_max_idx (o_max_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_rd_en) rd_data <= mem[o_rd_addr];
    end

    initial begin
        cyc = 0;
        start_cyc = 0;
        valid_cnt = 0;
        valid_cyc = 0;
        rd_cnt = 0;
    end

    always @(posedge clk) begin
        if (i_start) start_cyc <= cyc;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (o_valid) begin
            valid_cnt = valid_cnt + 1;
            valid_cyc = cyc;
        end
        if (o_rd_en) rd_cnt = rd_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents indices lo..hi; optional bubble of bub_len cycles after index bub_after,
    // during which i_done is raised without i_en.
    task automatic feed(input int lo, input int hi, input bit last, input int bub_after,
                        input int bub_len);
        for (int i = lo; i <= hi; i++) begin
            i_en      = 1'b1;
            i_value_i = 8'(i);
            i_done    = last && (i == hi);
            tick();
            if (i == bub_after) begin
                i_en   = 1'b0;
                i_done = 1'b1;
                repeat (bub_len) tick();
            end
        end
        i_en   = 1'b0;
        i_done = 1'b0;
    endtask

    task automatic start_scan();
        vbase   = valid_cnt;
        rbase   = rd_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Called in cycle T+1 after the last index was presented in cycle T.
    task automatic wait_done(input string tag, input logic [15:0] emax, input logic [7:0] eidx,
                             input int lat);
        @(negedge clk);
        chk($sformatf("%s_rd_en_t1", tag), o_rd_en, 1);
        chk($sformatf("%s_valid_t1", tag), o_valid, 0);
        tick();
        @(negedge clk);
        chk($sformatf("%s_valid_t2", tag), o_valid, 0);
        tick();
        @(negedge clk);
        chk($sformatf("%s_valid_t3", tag), o_valid, 1);
        chk($sformatf("%s_max", tag), o_max, emax);
        chk($sformatf("%s_max_idx", tag), o_max_idx, eidx);
        tick();
        @(negedge clk);
        chk($sformatf("%s_valid_t4", tag), o_valid, 0);
        chk($sformatf("%s_busy_t4", tag), o_busy, 0);
        chk($sformatf("%s_max_hold", tag), o_max, emax);
        chk($sformatf("%s_valid_cnt", tag), valid_cnt - vbase, 1);
        chk($sformatf("%s_latency", tag), valid_cyc - start_cyc, lat);
        tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        i_start   = 1'b0;
        i_en      = 1'b0;
        i_value_i = 8'd0;
        i_done    = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'd0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk("rst_rd_en", o_rd_en, 0);
        chk("rst_rd_addr", o_rd_addr, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_max", o_max, 0);
        chk("rst_max_idx", o_max_idx, 0);
        rst_n = 1'b1;
        tick();

        // 8 elements with a tie on the maximum
        mem[0] = 16'd3; mem[1] = 16'd9; mem[2] = 16'd2; mem[3] = 16'd9;
        mem[4] = 16'd7; mem[5] = 16'd1; mem[6] = 16'd0; mem[7] = 16'd5;
        start_scan();
        @(negedge clk);
        chk("t1_busy", o_busy, 1);
        feed(0, 7, 1'b1, -1, 0);
        wait_done("t1", 16'd9, 8'd1, 11);
        chk("t1_reads", rd_cnt - rbase, 8);

        // Same array with a 4-cycle bubble after index 3
        start_scan();
        feed(0, 7, 1'b1, 3, 4);
        wait_done("t2", 16'd9, 8'd1, 15);
        chk("t2_reads", rd_cnt - rbase, 8);

        // Single element scan, index arrives together with i_start
        mem[0]    = 16'hFFFF;
        vbase     = valid_cnt;
        i_start   = 1'b1;
        i_en      = 1'b1;
        i_value_i = 8'd0;
        i_done    = 1'b1;
        tick();
        i_start = 1'b0;
        i_en    = 1'b0;
        i_done  = 1'b0;
        wait_done("t3", 16'hFFFF, 8'd0, 3);

        // Restart after index 4 of a 32-element scan
        for (int i = 0; i < 32; i++) mem[i] = 16'(i * 3);
        mem[2]  = 16'hFFFF;
        mem[3]  = 16'hF001;
        mem[4]  = 16'hF000;
        mem[20] = 16'h8000;
        mem[27] = 16'h8000;
        start_scan();
        feed(0, 4, 1'b0, -1, 0);
        @(negedge clk);
        chk("t4_pre_max", o_max, 16'hFFFF);
        chk("t4_pre_idx", o_max_idx, 2);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        @(negedge clk);
        chk("t4_clr_max", o_max, 0);
        chk("t4_clr_idx", o_max_idx, 0);
        chk("t4_clr_busy", o_busy, 1);
        chk("t4_clr_rd_en", o_rd_en, 0);
        feed(5, 31, 1'b1, -1, 0);
        wait_done("t4", 16'h8000, 8'd20, 30);

        // Synchronous reset mid-scan
        start_scan();
        feed(0, 3, 1'b0, -1, 0);
        i_en      = 1'b1;
        i_value_i = 8'd4;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        i_en  = 1'b0;
        @(negedge clk);
        chk("t5_rd_en", o_rd_en, 0);
        chk("t5_rd_addr", o_rd_addr, 0);
        chk("t5_busy", o_busy, 0);
        chk("t5_valid", o_valid, 0);
        chk("t5_max", o_max, 0);
        chk("t5_max_idx", o_max_idx, 0);
        vbase = valid_cnt;
        rbase = rd_cnt;
        feed(4, 7, 1'b1, -1, 0);
        repeat (4) tick();
        @(negedge clk);
        chk("t5_no_reads", rd_cnt - rbase, 0);
        chk("t5_no_valid", valid_cnt - vbase, 0);
        chk("t5_idle_busy", o_busy, 0);
        tick();

        // 32 equal elements
        for (int i = 0; i < 32; i++) mem[i] = 16'h1234;
        start_scan();
        feed(0, 31, 1'b1, -1, 0);
        wait_done("t6", 16'h1234, 8'd0, 35);
        chk("t6_reads", rd_cnt - rbase, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
